// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port unified memory.
// The instruction-fetch (IF) and data (D) ports are serialised through an
// IDLE -> ISSUE -> [WAIT x MEM_LAT] -> RESP sequence. Contention is resolved
// by alternating grants, so neither port can starve. Stalls tell the core to
// hold its PC and pipeline state while a request is pending.
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  // instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  // memory macro side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Fairness bit: remembers whether the most recent grant went to D.
  logic last_was_d_q, last_was_d_d;
  // Owner of the transaction in flight: 1 = D port, 0 = IF port.
  logic gnt_d_q, gnt_d_d;
  // Remaining WAIT cycles for a read.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered memory interface. mem_addr/mem_wdata double as the latched
  // request, so later changes on the requester inputs have no effect.
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Per-port response registers; rdata only moves when that port's read ends.
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;

  // Arbitration result for the current IDLE cycle.
  logic grant_d;

  // Grant D when it is alone, or when both ask and D did not win last time.
  always_comb begin
    grant_d = d_req && (!if_req || !last_was_d_q);
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    last_was_d_d = last_was_d_q;
    gnt_d_d      = gnt_d_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_d_d      = grant_d;
          last_was_d_d = grant_d;
          // Memory strobes are loaded here so they are high exactly in ISSUE.
          mem_en_d     = 1'b1;
          mem_we_d     = grant_d && d_we;
          mem_addr_d   = grant_d ? d_addr : if_addr;
          if (grant_d) begin
            mem_wdata_d = d_wdata;
          end
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_we_q) begin
          // Writes complete without waiting on the memory.
          d_ready_d  = gnt_d_q;
          if_ready_d = !gnt_d_q;
          state_d    = RESP;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last WAIT cycle: memory data is valid now.
          if (gnt_d_q) begin
            d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        // The requester still holds req here, so never re-grant in RESP.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      last_was_d_q <= 1'b0;
      gnt_d_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_was_d_q <= last_was_d_d;
      gnt_d_q      <= gnt_d_d;
      cnt_q        <= cnt_d;
    end
  end

  // Output registers towards the memory and both requesters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  // Stalls follow req combinationally and drop in the ready cycle.
  always_comb begin
    if_stall = if_req && !if_ready_q;
    d_stall  = d_req && !d_ready_q;
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;

endmodule
